// File: rtl/core_pipe_exec_mdu_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the master side; the MDU sits on the slave side.
interface core_pipe_exec_mdu_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;

  modport master (
    output req_valid, req_op, req_word, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_word, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/core_pipe_exec_mdu.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Sign-magnitude operation: unsigned shift-add multiply / restoring divide, sign applied on DONE entry.
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 flush,
  core_pipe_exec_mdu_if.slave  mdu
);
  localparam int            CW         = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST_W = CW'(32 / MUL_UNROLL - 1);
  localparam logic [CW-1:0] MUL_LAST_X = CW'(XLEN / MUL_UNROLL - 1);
  localparam logic [CW-1:0] DIV_LAST_W = CW'(31);
  localparam logic [CW-1:0] DIV_LAST_X = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = s & v[31];
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              word_q, neg_q;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_d, mcand_d, prod;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   quo_q, rem_q, dvsr_q, quo_d, rem_d;
  logic [XLEN-1:0]   result_q;
  logic [CW-1:0]     cnt_q, mul_last, div_last;
  logic [XLEN:0]     div_sh, div_diff;

  logic            accept, in_div, a_signed, b_signed, sa, sb, b_zero, div_ovf, special, last_iter;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, w_min, dividend_res, special_res;
  logic [XLEN-1:0] mul_res, div_raw, div_res, fin_raw, fin_res;

  // Operand decode on the accept cycle: extend, take magnitudes, spot the one-cycle divide cases.
  assign accept   = mdu.req_valid && (state_q == IDLE) && !flush;
  assign in_div   = mdu.req_op[2];
  assign a_signed = in_div ? !mdu.req_op[0] : (mdu.req_op != 3'd3);
  assign b_signed = in_div ? !mdu.req_op[0] : !mdu.req_op[1];
  assign a_ext    = mdu.req_word ? ext_word(mdu.req_rs1, a_signed) : mdu.req_rs1;
  assign b_ext    = mdu.req_word ? ext_word(mdu.req_rs2, b_signed) : mdu.req_rs2;
  assign sa       = a_signed && (mdu.req_word ? mdu.req_rs1[31] : mdu.req_rs1[XLEN-1]);
  assign sb       = b_signed && (mdu.req_word ? mdu.req_rs2[31] : mdu.req_rs2[XLEN-1]);
  assign a_mag    = sa ? -a_ext : a_ext;
  assign b_mag    = sb ? -b_ext : b_ext;
  assign w_min    = mdu.req_word ? (XLEN'(1) << 31) : (XLEN'(1) << (XLEN - 1));
  assign b_zero   = (b_ext == '0);
  assign div_ovf  = in_div && b_signed && sa && (a_mag == w_min) && (b_ext == '1);
  assign special  = in_div && (b_zero || div_ovf);

  assign dividend_res = mdu.req_word ? ext_word(mdu.req_rs1, 1'b1) : mdu.req_rs1;
  assign special_res  = b_zero ? (mdu.req_op[1] ? dividend_res : '1)
                               : (mdu.req_op[1] ? '0 : dividend_res);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    for (int k = 0; k < MUL_UNROLL; k++) begin
      if (mplier_d[0]) acc_d = acc_d + mcand_d;
      mcand_d  = mcand_d << 1;
      mplier_d = mplier_d >> 1;
    end
  end

  // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
  assign div_sh   = {rem_q, quo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, dvsr_q};
  assign rem_d    = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
  assign quo_d    = {quo_q[XLEN-2:0], !div_diff[XLEN]};

  assign prod    = neg_q ? -acc_d : acc_d;
  assign mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0]
                 : (word_q ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN]);
  assign div_raw = op_q[1] ? rem_d : quo_d;
  assign div_res = neg_q ? -div_raw : div_raw;
  assign fin_raw = (state_q == DIV) ? div_res : mul_res;
  assign fin_res = word_q ? ext_word(fin_raw, 1'b1) : fin_raw;

  assign mul_last  = word_q ? MUL_LAST_W : MUL_LAST_X;
  assign div_last  = word_q ? DIV_LAST_W : DIV_LAST_X;
  assign last_iter = ((state_q == MUL) && (cnt_q == mul_last)) ||
                     ((state_q == DIV) && (cnt_q == div_last));

  assign mdu.req_ready  = (state_q == IDLE) && !flush;
  assign mdu.rsp_valid  = (state_q == DONE);
  assign mdu.rsp_result = (state_q == DONE) ? result_q : '0;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = special ? DONE : (in_div ? DIV : MUL);
        MUL,
        DIV:     if (last_iter) state_d = DONE;
        DONE:    if (mdu.rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q     <= mdu.req_op;
          word_q   <= mdu.req_word;
          neg_q    <= (in_div && mdu.req_op[1]) ? sa : (sa ^ sb);
          acc_q    <= '0;
          mcand_q  <= {{XLEN{1'b0}}, a_mag};
          mplier_q <= b_mag;
          quo_q    <= mdu.req_word ? (a_mag << (XLEN - 32)) : a_mag;
          rem_q    <= '0;
          dvsr_q   <= b_mag;
          cnt_q    <= '0;
          if (special) result_q <= special_res;
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) result_q <= fin_res;
        end
        DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) result_q <= fin_res;
        end
        default: ;
      endcase
    end
  end
endmodule
